pmu_ctl: RTL and testbench

- Memory-mapped power-management controller inside main; the initiator that drives the pmu_bus request lines (shutdown, reset) consumed by the board top level.
- Firmware writes a keyed command; after a programmable delay the block asserts the shdn or rst request for a fixed number of cycles, then returns to idle.
- Optional watchdog issues a reset request if firmware stops kicking it.

---
 rtl/pmu_ctl.sv | 169 ++++++++++++++++
 tb/tb_pmu_ctl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pmu_ctl.sv
// pmu_ctl: memory-mapped power-management controller.
// Keyed CTRL writes schedule a shutdown or reset request on pmu_bus after a
// programmable delay. The request is held for PULSE_LEN cycles.
// The optional watchdog is compiled in with `define PMU_WDT_EN.
module pmu_ctl #(
  parameter logic [15:0] KEY       = 16'hB0A5,
  parameter int          PULSE_LEN = 4,
  parameter int          DELAY_W   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic        re,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        pmu_shdn,
  output logic        pmu_rst,
  output logic        busy
);

  localparam logic [3:0] A_CTRL   = 4'h0;
  localparam logic [3:0] A_DELAY  = 4'h4;
  localparam logic [3:0] A_WDT    = 4'h8;
  localparam logic [3:0] A_STATUS = 4'hC;

  localparam logic [1:0] C_SHDN  = 2'b01;
  localparam logic [1:0] C_RST   = 2'b10;
  localparam logic [1:0] C_ABORT = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ASSERT} state_t;

  state_t               state_q, state_n;
  logic [1:0]           cmd_q, cmd_n;
  logic [DELAY_W-1:0]   delay_q, cnt_q;
  logic [7:0]           pcnt_q;
  logic                 key_err_q, wdt_fired_q;
  logic                 shdn_n, rstreq_n, busy_n;
  logic                 wdt_fire;
  logic [23:0]          wdt_rd;

  logic ctrl_wr, key_ok, start, abort, bad_ctrl, status_rd;
  assign ctrl_wr   = we && (addr == A_CTRL);
  assign key_ok    = (wdata[31:16] == KEY);
  assign start     = ctrl_wr && key_ok && (state_q == S_IDLE) &&
                     ((wdata[1:0] == C_SHDN) || (wdata[1:0] == C_RST));
  assign abort     = ctrl_wr && key_ok && (state_q != S_IDLE) &&
                     (wdata[1:0] == C_ABORT);
  assign bad_ctrl  = ctrl_wr && !start && !abort;
  assign status_rd = re && (addr == A_STATUS);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_n;
  end

  // Next-state and next-command logic; a watchdog expiry preempts everything
  always_comb begin
    state_n = state_q;
    cmd_n   = cmd_q;
    if (wdt_fire) begin
      state_n = S_ASSERT;
      cmd_n   = C_RST;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          state_n = S_WAIT;
          cmd_n   = wdata[1:0];
        end
        S_WAIT: if (abort) begin
          state_n = S_IDLE;
          cmd_n   = 2'b00;
        end else if (cnt_q == '0) begin
          state_n = S_ASSERT;
        end
        S_ASSERT: if (abort || (pcnt_q == 8'd0)) begin
          state_n = S_IDLE;
          cmd_n   = 2'b00;
        end
        default: begin
          state_n = S_IDLE;
          cmd_n   = 2'b00;
        end
      endcase
    end
  end

  // Output decode from the next state, so the request lines come straight from flops
  always_comb begin
    shdn_n   = (state_n == S_ASSERT) && (cmd_n == C_SHDN);
    rstreq_n = (state_n == S_ASSERT) && (cmd_n == C_RST);
    busy_n   = (state_n != S_IDLE);
  end

  // Registered outputs, command, counters and sticky flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pmu_shdn    <= 1'b0;
      pmu_rst     <= 1'b0;
      busy        <= 1'b0;
      cmd_q       <= 2'b00;
      cnt_q       <= '0;
      pcnt_q      <= 8'd0;
      key_err_q   <= 1'b0;
      wdt_fired_q <= 1'b0;
    end else begin
      pmu_shdn    <= shdn_n;
      pmu_rst     <= rstreq_n;
      busy        <= busy_n;
      cmd_q       <= cmd_n;
      if (start && !wdt_fire)                  cnt_q <= delay_q;
      else if (state_q == S_WAIT && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
      if (state_n == S_ASSERT && state_q != S_ASSERT) pcnt_q <= 8'(PULSE_LEN - 1);
      else if (state_q == S_ASSERT && pcnt_q != 8'd0) pcnt_q <= pcnt_q - 8'd1;
      // A new event wins over the clear from a concurrent STATUS read
      key_err_q   <= bad_ctrl | (key_err_q & ~status_rd);
      wdt_fired_q <= wdt_fire | (wdt_fired_q & ~status_rd);
    end
  end

  // DELAY register and registered read port
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      delay_q <= '0;
      rdata   <= 32'd0;
    end else begin
      if (we && addr == A_DELAY) delay_q <= wdata[DELAY_W-1:0];
      rdata <= 32'd0;
      if (re) begin
        case (addr)
          A_DELAY:  rdata <= 32'(delay_q);
          A_WDT:    rdata <= {8'd0, wdt_rd};
          A_STATUS: rdata <= {27'd0, key_err_q, wdt_fired_q, cmd_q, busy};
          default:  rdata <= 32'd0;
        endcase
      end
    end
  end

`ifdef PMU_WDT_EN
  logic [23:0] wdt_reload_q, wdt_cnt_q;
  logic        wdt_en_q;

  assign wdt_fire = wdt_en_q && (wdt_cnt_q == 24'd0) && (state_q != S_ASSERT);
  assign wdt_rd   = wdt_reload_q;

  // Watchdog: any write reloads, zero disables, expiry disarms until next write
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wdt_reload_q <= 24'd0;
      wdt_cnt_q    <= 24'd0;
      wdt_en_q     <= 1'b0;
    end else if (we && addr == A_WDT) begin
      wdt_reload_q <= wdata[23:0];
      wdt_cnt_q    <= wdata[23:0];
      wdt_en_q     <= |wdata[23:0];
    end else if (wdt_fire) begin
      wdt_en_q     <= 1'b0;
    end else if (wdt_en_q && state_q != S_ASSERT) begin
      wdt_cnt_q    <= wdt_cnt_q - 24'd1;
    end
  end
`else
  assign wdt_fire = 1'b0;
  assign wdt_rd   = 24'd0;
`endif

endmodule

// File: tb/tb_pmu_ctl.sv
// tb_pmu_ctl: directed bench for pmu_ctl with a read-data scoreboard.
module tb_pmu_ctl;

  localparam logic [3:0] A_CTRL   = 4'h0;
  localparam logic [3:0] A_DELAY  = 4'h4;
  localparam logic [3:0] A_WDT    = 4'h8;
  localparam logic [3:0] A_STATUS = 4'hC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [3:0]  addr = 4'h0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        pmu_shdn, pmu_rst, busy;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  pmu_ctl dut (
    .clk(clk), .rst_n(rst_n), .we(we), .re(re), .addr(addr), .wdata(wdata),
    .rdata(rdata), .pmu_shdn(pmu_shdn), .pmu_rst(pmu_rst), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string tag);
    addr = a; re = 1'b1;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    tick();
    re = 1'b0;
    chk(tag_q.pop_front(), rdata, exp_q.pop_front());
  endtask

  // Compare {pmu_shdn, pmu_rst, busy} against the expected triple
  task automatic outs(input string tag, input logic s, input logic r, input logic b);
    chk(tag, {29'd0, pmu_shdn, pmu_rst, busy}, {29'd0, s, r, b});
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    tick(); tick();
    outs("reset_outs", 1'b0, 1'b0, 1'b0);
    chk("reset_rdata", rdata, 32'd0);
    rst_n = 1'b1;
    rd(A_STATUS, 32'd0, "reset_status");
    rd(A_DELAY, 32'd0, "reset_delay");

    // Shutdown with DELAY=5: request on cycles 6..9
    wr(A_DELAY, 32'd5);
    wr(A_CTRL, 32'hB0A5_0001);
    outs("t1_k0", 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 11; k++) begin
      tick();
      outs($sformatf("t1_k%0d", k), (k >= 6 && k <= 9), 1'b0, (k <= 9));
    end
    rd(A_STATUS, 32'd0, "t1_status");

    // Bad key: no request, sticky key_err cleared by read
    wr(A_CTRL, 32'h1234_0002);
    outs("t2_k0", 1'b0, 1'b0, 1'b0);
    tick();
    outs("t2_k1", 1'b0, 1'b0, 1'b0);
    rd(A_STATUS, 32'h10, "t2_status1");
    rd(A_STATUS, 32'h00, "t2_status2");

    // Abort a long-delay reset at cycle 20
    wr(A_DELAY, 32'd100);
    wr(A_CTRL, 32'hB0A5_0002);
    for (int k = 1; k <= 19; k++) begin
      tick();
      outs($sformatf("t3_k%0d", k), 1'b0, 1'b0, 1'b1);
    end
    wr(A_CTRL, 32'hB0A5_0003);
    outs("t3_abort", 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      outs($sformatf("t3_post%0d", k), 1'b0, 1'b0, 1'b0);
    end
    rd(A_STATUS, 32'd0, "t3_status");

    // Zero delay reset: request on cycles 1..4
    wr(A_DELAY, 32'd0);
    wr(A_CTRL, 32'hB0A5_0002);
    outs("t4_k0", 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      tick();
      outs($sformatf("t4_k%0d", k), 1'b0, (k <= 4), (k <= 4));
    end

    // Reset mid-command drops everything
    wr(A_DELAY, 32'd10);
    wr(A_CTRL, 32'hB0A5_0001);
    tick(); tick();
    rst_n = 1'b0;
    tick();
    outs("t5_reset", 1'b0, 1'b0, 1'b0);
    chk("t5_rdata", rdata, 32'd0);
    rst_n = 1'b1;
    rd(A_DELAY, 32'd0, "t5_delay");
    for (int k = 1; k <= 15; k++) begin
      tick();
      outs($sformatf("t5_post%0d", k), 1'b0, 1'b0, 1'b0);
    end

    // Writes while busy: stray command flags key_err, DELAY change is deferred
    wr(A_DELAY, 32'd20);
    wr(A_CTRL, 32'hB0A5_0001);
    wr(A_CTRL, 32'hB0A5_0002);
    wr(A_DELAY, 32'd7);
    rd(A_STATUS, 32'h13, "t6_status_busy");
    for (int k = 4; k <= 26; k++) begin
      tick();
      outs($sformatf("t6_k%0d", k), (k >= 21 && k <= 24), 1'b0, (k <= 24));
    end
    rd(A_DELAY, 32'd7, "t6_delay");
    rd(A_STATUS, 32'd0, "t6_status_idle");

    // Simultaneous read and write of STATUS
    wr(A_CTRL, 32'h0000_0001);
    addr = A_STATUS; wdata = 32'hFFFF_FFFF; re = 1'b1; we = 1'b1;
    exp_q.push_back(32'h10);
    tag_q.push_back("t7_rw_status");
    tick();
    re = 1'b0; we = 1'b0;
    chk(tag_q.pop_front(), rdata, exp_q.pop_front());
    rd(A_STATUS, 32'd0, "t7_status_after");
    rd(A_CTRL, 32'd0, "t7_ctrl_read");

`ifdef PMU_WDT_EN
    // Unkicked watchdog fires at cycle 51
    wr(A_WDT, 32'd50);
    for (int k = 1; k <= 56; k++) begin
      tick();
      outs($sformatf("t8_k%0d", k), 1'b0, (k >= 51 && k <= 54), (k >= 51 && k <= 54));
    end
    rd(A_STATUS, 32'h08, "t8_status");
    rd(A_WDT, 32'd50, "t8_wdt_read");
    // Kicked every 40 cycles: never fires
    wr(A_WDT, 32'd50);
    for (int i = 1; i <= 500; i++) begin
      if (i % 40 == 0) wr(A_WDT, 32'd50);
      else             tick();
      outs($sformatf("t9_i%0d", i), 1'b0, 1'b0, 1'b0);
    end
    wr(A_WDT, 32'd0);
    rd(A_STATUS, 32'd0, "t9_status");
`else
    // Without the watchdog, 0x8 is inert
    wr(A_WDT, 32'd50);
    rd(A_WDT, 32'd0, "t8_wdt_read");
    for (int k = 1; k <= 60; k++) begin
      tick();
      outs($sformatf("t8_k%0d", k), 1'b0, 1'b0, 1'b0);
    end
    rd(A_STATUS, 32'd0, "t8_status");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
